// File: rtl/taylor_pkg.sv
// rtl/taylor_pkg.sv - shared constants, state codes and fixed-point helpers for taylor_eval
package taylor_pkg;

    localparam logic [1:0] MODE_COS = 2'b00;
    localparam logic [1:0] MODE_SIN = 2'b01;
    localparam logic [1:0] MODE_EXP = 2'b10;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_INIT  = 3'd1;
    localparam state_t S_TERM  = 3'd2;
    localparam state_t S_POWER = 3'd3;
    localparam state_t S_DONE  = 3'd4;

    localparam int DEF_FRAC = 13;
    localparam int ONE      = 1 << DEF_FRAC;

    // The INIT squaring shares the single multiplier in its otherwise idle cycle.
    localparam int LAT_EXTRA = 0;

    typedef struct packed {
        logic signed [31:0] val;
        logic               sat;
    } sat_t;

    function automatic sat_t sat_to(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_t r;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r.sat = (v > hi) || (v < lo);
        if (v > hi)
            r.val = hi[31:0];
        else if (v < lo)
            r.val = lo[31:0];
        else
            r.val = v[31:0];
        return r;
    endfunction

    // Full-width signed product, floor shift by frac, then clamp to w bits.
    function automatic sat_t mul_sat(input logic signed [31:0] a, input logic signed [31:0] b,
                                     input int w, input int frac);
        logic signed [63:0] p;
        p = $signed(64'(a)) * $signed(64'(b));
        p = p >>> frac;
        return sat_to(p, w);
    endfunction

    // Rounded 1/order! in Q format; the factorial is capped once the quotient is surely zero.
    function automatic longint coef_q(input logic [1:0] mode, input int k, input int frac);
        longint f;
        int     order;
        if (mode == MODE_COS)
            order = 2 * k;
        else if (mode == MODE_SIN)
            order = 2 * k + 1;
        else
            order = k;
        f = 1;
        for (int i = 2; i <= order; i++)
            if (f < (longint'(1) <<< 40))
                f = f * longint'(i);
        if (mode == 2'b11)
            return 0;
        return ((longint'(1) <<< frac) + f / 2) / f;
    endfunction

endpackage

// File: rtl/taylor_coef_rom.sv
// rtl/taylor_coef_rom.sv - combinational Taylor coefficient table indexed by mode and term
module taylor_coef_rom
    import taylor_pkg::*;
#(
    parameter int W    = 16,
    parameter int FRAC = 13,
    parameter int NT   = 8,
    parameter int IW   = 3
) (
    input  logic [1:0]    mode,
    input  logic [IW-1:0] idx,
    output logic [W-1:0]  coef
);

    logic [W-1:0] tbl [4][NT];

    for (genvar m = 0; m < 4; m++) begin : g_mode
        for (genvar k = 0; k < NT; k++) begin : g_term
            assign tbl[m][k] = W'(coef_q(2'(m), k, FRAC));
        end
    end

    assign coef = tbl[mode][idx];

endmodule

// File: rtl/taylor_eval.sv
// rtl/taylor_eval.sv - start/done series evaluator for cos, sin and exp with one shared multiplier
module taylor_eval
    import taylor_pkg::*;
#(
    parameter int W    = 16,
    parameter int FRAC = 13,
    parameter int NT   = 8,
    parameter int CW   = $clog2(NT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [W-1:0]  x,
    input  logic [CW-1:0] n_terms,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  out,
    output logic          ovf
);

    localparam int IW = (NT > 1) ? $clog2(NT) : 1;
    localparam int AW = W + 4;
    localparam logic signed [W-1:0] ONE_W = W'(1 << FRAC);

    state_t               state;
    logic signed [W-1:0]  x_r;
    logic signed [W-1:0]  step;
    logic signed [W-1:0]  temp;
    logic [1:0]           mode_r;
    logic [CW-1:0]        n_r;
    logic [IW-1:0]        cnt;
    logic signed [AW-1:0] acc;
    logic                 ovf_r;

    logic [W-1:0]         coef;
    logic signed [31:0]   mul_a;
    logic signed [31:0]   mul_b;
    sat_t                 mul_r;
    logic signed [W-1:0]  mul_val;
    logic signed [AW-1:0] term;
    logic signed [AW-1:0] acc_next;
    sat_t                 acc_sat;
    logic                 skip;
    logic                 neg;

    taylor_coef_rom #(.W(W), .FRAC(FRAC), .NT(NT), .IW(IW)) u_rom (
        .mode (mode_r),
        .idx  (cnt),
        .coef (coef)
    );

    // INIT squares x, POWER advances the power, TERM scales it by the coefficient.
    always_comb begin
        mul_a = 32'($signed(coef));
        mul_b = 32'(temp);
        case (state)
            S_INIT: begin
                mul_a = 32'(x_r);
                mul_b = 32'(x_r);
            end
            S_POWER: begin
                mul_a = 32'(temp);
                mul_b = 32'(step);
            end
            default: ;
        endcase
    end

    assign mul_r    = mul_sat(mul_a, mul_b, W, FRAC);
    assign mul_val  = mul_r.val[W-1:0];
    assign term     = AW'(mul_val);
    assign neg      = (mode_r != MODE_EXP) && cnt[0];
    assign acc_next = neg ? (acc - term) : (acc + term);
    assign acc_sat  = sat_to(64'(acc), W);
    assign skip     = (n_r == '0) || (mode_r == 2'b11);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            x_r    <= '0;
            step   <= '0;
            temp   <= '0;
            mode_r <= '0;
            n_r    <= '0;
            cnt    <= '0;
            acc    <= '0;
            ovf_r  <= 1'b0;
            done   <= 1'b0;
            out    <= '0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_r    <= x;
                        mode_r <= mode;
                        n_r    <= (n_terms > CW'(NT)) ? CW'(NT) : n_terms;
                        state  <= S_INIT;
                    end
                end
                S_INIT: begin
                    step  <= (mode_r == MODE_EXP) ? x_r : mul_val;
                    temp  <= (mode_r == MODE_SIN) ? x_r : ONE_W;
                    acc   <= '0;
                    cnt   <= '0;
                    ovf_r <= ((mode_r == MODE_COS) || (mode_r == MODE_SIN)) && mul_r.sat;
                    state <= skip ? S_DONE : S_TERM;
                end
                S_TERM: begin
                    acc   <= acc_next;
                    ovf_r <= ovf_r | mul_r.sat;
                    state <= (CW'(cnt) == n_r - 1'b1) ? S_DONE : S_POWER;
                end
                S_POWER: begin
                    temp  <= mul_val;
                    ovf_r <= ovf_r | mul_r.sat;
                    cnt   <= cnt + 1'b1;
                    state <= S_TERM;
                end
                S_DONE: begin
                    out   <= skip ? '0 : acc_sat.val[W-1:0];
                    ovf   <= ovf_r | acc_sat.sat;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_taylor_eval.sv
// tb/tb_taylor_eval.sv - scoreboard bench for taylor_eval
module tb_taylor_eval;

    localparam int W    = 16;
    localparam int FRAC = 13;
    localparam int NT   = 8;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [W-1:0]  x;
    logic [CW-1:0] n_terms;
    logic          busy;
    logic          done;
    logic [W-1:0]  out;
    logic          ovf;

    always #5 clk = ~clk;

    taylor_eval #(.W(W), .FRAC(FRAC), .NT(NT), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mode    (mode),
        .x       (x),
        .n_terms (n_terms),
        .busy    (busy),
        .done    (done),
        .out     (out),
        .ovf     (ovf)
    );

    typedef struct {
        int out_v;
        int tol;
        int ovf_v;
        int lat;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    int n_acc  = 0;
    int n_done = 0;
    logic busy_q = 1'b0;

    task automatic check(input string tag, input int got, input int want, input int tol = 0);
        int d;
        n_chk++;
        d = got - want;
        if (d < 0) d = -d;
        if (d <= tol)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, want, tol);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t  e;
        string t;
        if (busy && !busy_q) begin
            acc_cyc = cyc;
            n_acc++;
        end
        busy_q = busy;
        if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check({t, "_out"}, int'($signed(out)), e.out_v, e.tol);
                check({t, "_ovf"}, int'(ovf), e.ovf_v);
                check({t, "_lat"}, cyc - acc_cyc, e.lat);
            end
        end
    end

    task automatic push_exp(input string tag, input int eo, input int tol, input int eovf, input int lat);
        exp_t e;
        e.out_v = eo;
        e.tol   = tol;
        e.ovf_v = eovf;
        e.lat   = lat;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic launch(input string tag, input logic [1:0] m, input int xv, input int n,
                          input int eo, input int tol, input int eovf, input int lat);
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy) check({tag, "_launch_timeout"}, 1, 0);
        mode    = m;
        x       = W'(xv);
        n_terms = CW'(n);
        start   = 1'b1;
        push_exp(tag, eo, tol, eovf, lat);
        @(negedge clk);
        start   = 1'b0;
        mode    = 2'($urandom);
        x       = W'($urandom);
        n_terms = CW'($urandom);
    endtask

    task automatic wait_quiet(input string tag);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0 || busy) begin
            check({tag, "_drain_timeout"}, exp_q.size(), 0);
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int done_before;
        int t;
        rst = 1'b0;
        start = 1'b0;
        mode = 2'b00;
        x = '0;
        n_terms = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_out", int'(out), 0);
        check("rst_ovf", int'(ovf), 0);
        rst = 1'b1;

        launch("cos0_n4", 2'b00, 0, 4, 8192, 0, 0, 9);
        launch("cos1", 2'b00, 8192, 5, 4426, 2, 0, 11);
        launch("cos_m1", 2'b00, -8192, 5, 4426, 2, 0, 11);
        launch("sin_half", 2'b01, 4096, 4, 3927, 2, 0, 9);
        launch("sin_n0", 2'b01, 4096, 0, 0, 0, 0, 2);
        launch("exp1", 2'b10, 8192, 8, 22268, 3, 0, 17);
        launch("exp1_clamp", 2'b10, 8192, 15, 22268, 3, 0, 17);
        launch("exp_sat", 2'b10, 15565, 8, 32767, 0, 1, 17);
        launch("cos0_after", 2'b00, 0, 4, 8192, 0, 0, 9);
        launch("mode11", 2'b11, 8192, 4, 0, 0, 0, 2);
        launch("sin_n1", 2'b01, 4096, 1, 4096, 0, 0, 3);
        wait_quiet("seq");

        done_before = n_done;
        @(negedge clk);
        mode = 2'b00;
        x = W'(8192);
        n_terms = CW'(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #2;
        check("abort_busy", int'(busy), 0);
        check("abort_out", int'(out), 0);
        check("abort_ovf", int'(ovf), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_done", n_done, done_before);

        mode = 2'b00;
        x = W'(8192);
        n_terms = CW'(2);
        for (int i = 0; i < 3; i++) push_exp("b2b", 4096, 0, 0, 5);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            t = 0;
            @(negedge clk);
            while (!done && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!done) check("b2b_wait_timeout", 1, 0);
            if (i == 2) begin
                start = 1'b0;
            end else begin
                @(negedge clk);
                check("b2b_accept_after_done", int'(busy), 1);
            end
        end
        wait_quiet("b2b");

        launch("exp_busy", 2'b10, 8192, 8, 22268, 3, 0, 17);
        repeat (3) @(negedge clk);
        mode = 2'b10;
        x = W'(100);
        n_terms = CW'(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_quiet("ignore");
        repeat (5) @(negedge clk);

        check("done_vs_accept", n_done, n_acc - 1);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
